// File: rtl/axi_slave_regs_pkg.sv
// rtl/axi_slave_regs_pkg.sv - shared states, responses and address helpers for axi_slave_regs
package axi_slave_regs_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_LSB = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Register index is the address above the byte-lane bits.
  function automatic logic idx_in_range(input logic [31:0] addr, input int unsigned num_regs);
    return {{ADDR_LSB{1'b0}}, addr[31:ADDR_LSB]} < num_regs;
  endfunction

endpackage

// File: rtl/axi_slave_regs_strb_merge.sv
// rtl/axi_slave_regs_strb_merge.sv - byte-strobe merge of new write data over old register data
module axi_slave_regs_strb_merge
  import axi_slave_regs_pkg::*;
(
  input  logic [DATA_W-1:0]   old_i,
  input  logic [DATA_W-1:0]   new_i,
  input  logic [DATA_W/8-1:0] strb_i,
  output logic [DATA_W-1:0]   merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (strb_i[b]) merged_o[8*b +: 8] = new_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/axi_slave_regs.sv
// rtl/axi_slave_regs.sv - AXI4 burst slave register bank with per-register write pulses
// Define AXI_SLAVE_REGS_SLVERR_EN to answer out-of-range beats with SLVERR.
module axi_slave_regs
  import axi_slave_regs_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 4,
  parameter logic [63:0] RESET_VAL = 64'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                axi_s_aw_addr,
  input  logic [7:0]                 axi_s_aw_len,
  input  logic                       axi_s_aw_valid,
  output logic                       axi_s_aw_ready,
  input  logic [63:0]                axi_s_w_data,
  input  logic [7:0]                 axi_s_w_strb,
  input  logic                       axi_s_w_last,
  input  logic                       axi_s_w_valid,
  output logic                       axi_s_w_ready,
  output logic [1:0]                 axi_s_b_resp,
  output logic                       axi_s_b_resp_valid,
  input  logic                       axi_s_b_resp_ready,
  input  logic [31:0]                axi_s_ar_addr,
  input  logic [7:0]                 axi_s_ar_len,
  input  logic                       axi_s_ar_valid,
  output logic                       axi_s_ar_ready,
  output logic [63:0]                axi_s_r_data,
  output logic [1:0]                 axi_s_r_resp,
  output logic                       axi_s_r_last,
  output logic                       axi_s_r_valid,
  input  logic                       axi_s_r_ready,
  output logic [NUM_REGS*64-1:0]     regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  wr_state_e           w_state_q, w_state_d;
  logic [31:0]         w_addr_q, w_addr_d;
  logic [7:0]          w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic                aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
  logic [1:0]          b_resp_q, b_resp_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [IDX_W-1:0]    w_idx;
  logic                w_hit;
  logic [DATA_W-1:0]   w_merged;
`ifdef AXI_SLAVE_REGS_SLVERR_EN
  logic                w_err_q, w_err_d;
`endif

  rd_state_e           r_state_q, r_state_d;
  logic [31:0]         r_addr_q, r_addr_d, r_fetch_addr;
  logic [7:0]          r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic                ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d;
  logic [DATA_W-1:0]   r_data_q, r_data_d;
  logic [1:0]          r_resp_q, r_resp_d;
  logic                r_fetch, r_hit;

  logic                unused_w_last;
  assign unused_w_last = axi_s_w_last;

  assign w_idx = w_addr_q[ADDR_LSB +: IDX_W];
  assign w_hit = idx_in_range(w_addr_q, NUM_REGS);

  axi_slave_regs_strb_merge u_strb_merge (
    .old_i    (regs_q[w_idx]),
    .new_i    (axi_s_w_data),
    .strb_i   (axi_s_w_strb),
    .merged_o (w_merged)
  );

  always_comb begin
    w_state_d  = w_state_q;
    w_addr_d   = w_addr_q;
    w_len_d    = w_len_q;
    w_cnt_d    = w_cnt_q;
    b_resp_d   = b_resp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
`ifdef AXI_SLAVE_REGS_SLVERR_EN
    w_err_d    = w_err_q;
`endif
    unique case (w_state_q)
      W_IDLE: if (axi_s_aw_valid && aw_ready_q) begin
        w_state_d = W_DATA;
        w_addr_d  = axi_s_aw_addr;
        w_len_d   = axi_s_aw_len;
        w_cnt_d   = '0;
`ifdef AXI_SLAVE_REGS_SLVERR_EN
        w_err_d   = 1'b0;
`endif
      end
      W_DATA: if (axi_s_w_valid && w_ready_q) begin
        if (w_hit) begin
          regs_d[w_idx]     = w_merged;
          wr_pulse_d[w_idx] = 1'b1;
        end
`ifdef AXI_SLAVE_REGS_SLVERR_EN
        if (!w_hit) w_err_d = 1'b1;
`endif
        w_addr_d = w_addr_q + 32'(DATA_W / 8);
        w_cnt_d  = w_cnt_q + 8'd1;
        if (w_cnt_q == w_len_q) begin
          w_state_d = W_RESP;
`ifdef AXI_SLAVE_REGS_SLVERR_EN
          b_resp_d  = (w_err_q || !w_hit) ? RESP_SLVERR : RESP_OKAY;
`else
          b_resp_d  = RESP_OKAY;
`endif
        end
      end
      W_RESP: if (axi_s_b_resp_ready && b_valid_q) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    aw_ready_d = (w_state_d == W_IDLE);
    w_ready_d  = (w_state_d == W_DATA);
    b_valid_d  = (w_state_d == W_RESP);
  end

  always_comb begin
    r_state_d    = r_state_q;
    r_addr_d     = r_addr_q;
    r_len_d      = r_len_q;
    r_cnt_d      = r_cnt_q;
    r_data_d     = r_data_q;
    r_resp_d     = r_resp_q;
    r_last_d     = r_last_q;
    r_fetch      = 1'b0;
    r_fetch_addr = r_addr_q + 32'(DATA_W / 8);
    unique case (r_state_q)
      R_IDLE: if (axi_s_ar_valid && ar_ready_q) begin
        r_state_d    = R_DATA;
        r_addr_d     = axi_s_ar_addr;
        r_len_d      = axi_s_ar_len;
        r_cnt_d      = '0;
        r_last_d     = (axi_s_ar_len == 8'd0);
        r_fetch      = 1'b1;
        r_fetch_addr = axi_s_ar_addr;
      end
      R_DATA: if (r_valid_q && axi_s_r_ready) begin
        if (r_cnt_q == r_len_q) begin
          r_state_d = R_IDLE;
          r_last_d  = 1'b0;
        end else begin
          r_addr_d  = r_fetch_addr;
          r_cnt_d   = r_cnt_q + 8'd1;
          r_last_d  = ((r_cnt_q + 8'd1) == r_len_q);
          r_fetch   = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Reads sample regs_q, so a same-cycle write is not yet visible.
    r_hit = idx_in_range(r_fetch_addr, NUM_REGS);
    if (r_fetch) begin
      r_data_d = r_hit ? regs_q[r_fetch_addr[ADDR_LSB +: IDX_W]] : '0;
`ifdef AXI_SLAVE_REGS_SLVERR_EN
      r_resp_d = r_hit ? RESP_OKAY : RESP_SLVERR;
`else
      r_resp_d = RESP_OKAY;
`endif
    end
    ar_ready_d = (r_state_d == R_IDLE);
    r_valid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q  <= W_IDLE;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_cnt_q    <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= RESET_VAL;
`ifdef AXI_SLAVE_REGS_SLVERR_EN
      w_err_q    <= 1'b0;
`endif
      r_state_q  <= R_IDLE;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_cnt_q    <= '0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      w_state_q  <= w_state_d;
      w_addr_q   <= w_addr_d;
      w_len_q    <= w_len_d;
      w_cnt_q    <= w_cnt_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
`ifdef AXI_SLAVE_REGS_SLVERR_EN
      w_err_q    <= w_err_d;
`endif
      r_state_q  <= r_state_d;
      r_addr_q   <= r_addr_d;
      r_len_q    <= r_len_d;
      r_cnt_q    <= r_cnt_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_last_q   <= r_last_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_regs_flat
    assign regs_o[64*i +: 64] = regs_q[i];
  end

  assign wr_pulse_o         = wr_pulse_q;
  assign axi_s_aw_ready     = aw_ready_q;
  assign axi_s_w_ready      = w_ready_q;
  assign axi_s_b_resp_valid = b_valid_q;
  assign axi_s_b_resp       = b_resp_q;
  assign axi_s_ar_ready     = ar_ready_q;
  assign axi_s_r_valid      = r_valid_q;
  assign axi_s_r_last       = r_last_q;
  assign axi_s_r_data       = r_data_q;
  assign axi_s_r_resp       = r_resp_q;

endmodule
